// File: rtl/acc_shift_pkg.sv
// acc_shift_pkg: mode encodings and width helper shared by the accumulate/shift register slice.
// Revision 1.0
`default_nettype none

package acc_shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD  = 2'b00;
  localparam mode_t MODE_LOAD  = 2'b01;
  localparam mode_t MODE_ACC   = 2'b10;
  localparam mode_t MODE_SHIFT = 2'b11;

  // Port width for a value range of n; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_shift_reg_if.sv
// acc_shift_reg_if: operation/result bundle between the multiplier control FSM and the product register.
// Revision 1.0
`default_nettype none

interface acc_shift_reg_if
  import acc_shift_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 4,
  parameter int NUM_ACC    = 4
);

  localparam int SAW = width_of(WIDTH / SHIFT_STEP);
  localparam int CW  = width_of(NUM_ACC);

  logic             clk_en;
  mode_t            mode;
  logic [WIDTH-1:0] datain;
  logic [SAW-1:0]   shift_amt;
  logic [WIDTH-1:0] reg_out;
  logic             ovf;
  logic [CW-1:0]    acc_cnt;
  logic             done;

  modport master (
    output clk_en, mode, datain, shift_amt,
    input  reg_out, ovf, acc_cnt, done
  );

  modport slave (
    input  clk_en, mode, datain, shift_amt,
    output reg_out, ovf, acc_cnt, done
  );

endinterface

`default_nettype wire

// File: rtl/acc_shift_reg_pp_align.sv
// pp_align: left-aligns a partial product by shift_amt*SHIFT_STEP bits and flags bits lost past WIDTH.
// Revision 1.0
`default_nettype none

module pp_align #(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 4,
  parameter int SAW        = 2
) (
  input  logic [WIDTH-1:0] datain,
  input  logic [SAW-1:0]   shift_amt,
  output logic [WIDTH-1:0] aligned,
  output logic             out_of_range
);

  localparam int SHW = $clog2(2 * WIDTH) + 1;

  logic [SHW-1:0]     shift_bits;
  logic [2*WIDTH-1:0] wide;

  // Shift at double width so the bits pushed beyond WIDTH stay visible for the overflow flag.
  always_comb begin
    shift_bits   = SHW'(shift_amt) * SHW'(SHIFT_STEP);
    wide         = {{WIDTH{1'b0}}, datain} << shift_bits;
    aligned      = wide[WIDTH-1:0];
    out_of_range = |wide[2*WIDTH-1:WIDTH];
  end

endmodule

`default_nettype wire

// File: rtl/acc_shift_reg.sv
// acc_shift_reg: product register with hold/load/shifted-accumulate/right-shift, sticky overflow and done pulse.
// Revision 1.0
`default_nettype none

module acc_shift_reg
  import acc_shift_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 4,
  parameter int NUM_ACC    = 4
) (
  input  logic           clk,
  input  logic           sclr,
  acc_shift_reg_if.slave bus
);

  localparam int SAW = width_of(WIDTH / SHIFT_STEP);
  localparam int CW  = width_of(NUM_ACC);

  logic [WIDTH-1:0] value;
  logic             ovf_flag;
  logic [CW-1:0]    count;
  logic             done_pulse;

  logic [WIDTH-1:0] aligned;
  logic             out_of_range;
  logic [WIDTH:0]   sum;
  logic             last_acc;

  pp_align #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .SAW        (SAW)
  ) u_pp_align (
    .datain       (bus.datain),
    .shift_amt    (bus.shift_amt),
    .aligned      (aligned),
    .out_of_range (out_of_range)
  );

  always_comb begin
    sum      = {1'b0, value} + {1'b0, aligned};
    last_acc = (count == CW'(NUM_ACC - 1));
  end

  // done defaults low every enabled or gated edge so it can only ever be a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!sclr) begin
      value      <= '0;
      ovf_flag   <= 1'b0;
      count      <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (bus.clk_en) begin
        case (bus.mode)
          MODE_LOAD: begin
            value    <= bus.datain;
            ovf_flag <= 1'b0;
            count    <= '0;
          end
          MODE_ACC: begin
            value    <= sum[WIDTH-1:0];
            ovf_flag <= ovf_flag | sum[WIDTH] | out_of_range;
            if (last_acc) begin
              count      <= '0;
              done_pulse <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
          MODE_SHIFT: begin
            value <= value >> SHIFT_STEP;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.reg_out = value;
  assign bus.ovf     = ovf_flag;
  assign bus.acc_cnt = count;
  assign bus.done    = done_pulse;

endmodule

`default_nettype wire

// File: tb/tb_acc_shift_reg.sv
// tb_acc_shift_reg: directed checks of acc_shift_reg with WIDTH=16, SHIFT_STEP=4, NUM_ACC=4.
`default_nettype none

module tb_acc_shift_reg;
  import acc_shift_pkg::*;

  logic clk = 1'b0;
  logic sclr;
  int   tests = 0;
  int   fails = 0;

  acc_shift_reg_if #(.WIDTH(16), .SHIFT_STEP(4), .NUM_ACC(4)) bus ();

  acc_shift_reg #(.WIDTH(16), .SHIFT_STEP(4), .NUM_ACC(4)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input mode_t m, input logic [15:0] d, input logic [1:0] sa);
    bus.clk_en    = en;
    bus.mode      = m;
    bus.datain    = d;
    bus.shift_amt = sa;
    tick();
  endtask

  task automatic test_reset();
    sclr = 1'b0;
    bus.clk_en = 1'b1; bus.mode = MODE_HOLD; bus.datain = '0; bus.shift_amt = '0;
    tick();
    tick();
    sclr = 1'b1;
    tests++;
    if (bus.reg_out !== 16'h0000 || bus.ovf !== 1'b0 || bus.acc_cnt !== 2'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset: reg_out=%h ovf=%b acc_cnt=%0d done=%b expected 0000/0/0/0",
               bus.reg_out, bus.ovf, bus.acc_cnt, bus.done);
    end
  endtask

  task automatic test_reset_enable_low();
    drive(1'b1, MODE_LOAD, 16'h5555, 2'd0);
    drive(1'b1, MODE_ACC, 16'hF000, 2'd1);  // 0x5555 + 0x0000 with truncated bits -> ovf=1, cnt=1
    tests++;
    if (bus.ovf !== 1'b1 || bus.acc_cnt !== 2'd1) begin
      fails++;
      $display("FAIL pre_reset_state: ovf=%b acc_cnt=%0d expected 1/1", bus.ovf, bus.acc_cnt);
    end
    sclr = 1'b0;
    drive(1'b0, MODE_LOAD, 16'hFFFF, 2'd0);
    drive(1'b0, MODE_LOAD, 16'hFFFF, 2'd0);
    sclr = 1'b1;
    tests++;
    if (bus.reg_out !== 16'h0000 || bus.ovf !== 1'b0 || bus.acc_cnt !== 2'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_en_low: reg_out=%h ovf=%b acc_cnt=%0d done=%b expected 0000/0/0/0",
               bus.reg_out, bus.ovf, bus.acc_cnt, bus.done);
    end
  endtask

  task automatic test_enable_gating();
    drive(1'b1, MODE_LOAD, 16'h1234, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, MODE_LOAD, 16'hFFFF, 2'd0);
      tests++;
      if (bus.reg_out !== 16'h1234 || bus.done !== 1'b0) begin
        fails++;
        $display("FAIL gating[%0d]: reg_out=%h done=%b expected 1234/0", i, bus.reg_out, bus.done);
      end
    end
  endtask

  task automatic test_full_product();
    logic [15:0] pp [4];
    pp[0] = 16'h0006; pp[1] = 16'h000C; pp[2] = 16'h0009; pp[3] = 16'h0002;
    drive(1'b1, MODE_LOAD, 16'h0000, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MODE_ACC, pp[i], 2'(i));
      tests++;
      if (bus.done !== 1'b0 || bus.acc_cnt !== 2'(i + 1)) begin
        fails++;
        $display("FAIL product_step[%0d]: done=%b acc_cnt=%0d expected 0/%0d", i, bus.done, bus.acc_cnt, i + 1);
      end
    end
    drive(1'b1, MODE_ACC, pp[3], 2'd3);
    tests++;
    if (bus.reg_out !== 16'h29C6 || bus.done !== 1'b1 || bus.acc_cnt !== 2'd0 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL product_done: reg_out=%h done=%b acc_cnt=%0d ovf=%b expected 29c6/1/0/0",
               bus.reg_out, bus.done, bus.acc_cnt, bus.ovf);
    end
    drive(1'b0, MODE_ACC, pp[3], 2'd3);
    tests++;
    if (bus.done !== 1'b0 || bus.reg_out !== 16'h29C6) begin
      fails++;
      $display("FAIL done_one_cycle: done=%b reg_out=%h expected 0/29c6", bus.done, bus.reg_out);
    end
    drive(1'b1, MODE_ACC, 16'h0001, 2'd0);  // wrap: new product starts at count 1
    tests++;
    if (bus.acc_cnt !== 2'd1 || bus.done !== 1'b0 || bus.reg_out !== 16'h29C7) begin
      fails++;
      $display("FAIL wrap: acc_cnt=%0d done=%b reg_out=%h expected 1/0/29c7", bus.acc_cnt, bus.done, bus.reg_out);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, MODE_LOAD, 16'hF000, 2'd0);
    drive(1'b1, MODE_ACC, 16'h1000, 2'd0);
    tests++;
    if (bus.reg_out !== 16'h0000 || bus.ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_carry: reg_out=%h ovf=%b expected 0000/1", bus.reg_out, bus.ovf);
    end
    drive(1'b1, MODE_ACC, 16'h0010, 2'd3);
    tests++;
    if (bus.reg_out !== 16'h0000 || bus.ovf !== 1'b1 || bus.acc_cnt !== 2'd2) begin
      fails++;
      $display("FAIL ovf_trunc: reg_out=%h ovf=%b acc_cnt=%0d expected 0000/1/2", bus.reg_out, bus.ovf, bus.acc_cnt);
    end
    drive(1'b1, MODE_LOAD, 16'h0001, 2'd0);
    tests++;
    if (bus.reg_out !== 16'h0001 || bus.ovf !== 1'b0 || bus.acc_cnt !== 2'd0) begin
      fails++;
      $display("FAIL ovf_clear: reg_out=%h ovf=%b acc_cnt=%0d expected 0001/0/0", bus.reg_out, bus.ovf, bus.acc_cnt);
    end
  endtask

  task automatic test_shift();
    logic [15:0] exp_val [2];
    exp_val[0] = 16'h0ABC; exp_val[1] = 16'h00AB;
    drive(1'b1, MODE_LOAD, 16'hABCD, 2'd0);
    drive(1'b1, MODE_ACC, 16'h0000, 2'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, MODE_SHIFT, 16'hFFFF, 2'd3);
      tests++;
      if (bus.reg_out !== exp_val[i] || bus.acc_cnt !== 2'd1 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
        fails++;
        $display("FAIL shift[%0d]: reg_out=%h acc_cnt=%0d done=%b ovf=%b expected %h/1/0/0",
                 i, bus.reg_out, bus.acc_cnt, bus.done, bus.ovf, exp_val[i]);
      end
    end
    drive(1'b1, MODE_HOLD, 16'hFFFF, 2'd3);
    tests++;
    if (bus.reg_out !== 16'h00AB || bus.acc_cnt !== 2'd1) begin
      fails++;
      $display("FAIL hold: reg_out=%h acc_cnt=%0d expected 00ab/1", bus.reg_out, bus.acc_cnt);
    end
  endtask

  task automatic test_reset_mid_product();
    drive(1'b1, MODE_LOAD, 16'h0000, 2'd0);
    drive(1'b1, MODE_ACC, 16'h0001, 2'd0);
    drive(1'b1, MODE_ACC, 16'h0001, 2'd0);
    tests++;
    if (bus.acc_cnt !== 2'd2 || bus.reg_out !== 16'h0002) begin
      fails++;
      $display("FAIL mid_pre: acc_cnt=%0d reg_out=%h expected 2/0002", bus.acc_cnt, bus.reg_out);
    end
    sclr = 1'b0;
    drive(1'b0, MODE_ACC, 16'h0001, 2'd0);
    sclr = 1'b1;
    tests++;
    if (bus.reg_out !== 16'h0000 || bus.ovf !== 1'b0 || bus.acc_cnt !== 2'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL mid_clear: reg_out=%h ovf=%b acc_cnt=%0d done=%b expected 0000/0/0/0",
               bus.reg_out, bus.ovf, bus.acc_cnt, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MODE_ACC, 16'h0001, 2'd0);
      tests++;
      if (bus.done !== 1'b0) begin
        fails++;
        $display("FAIL mid_no_done[%0d]: done=%b expected 0", i, bus.done);
      end
    end
    drive(1'b1, MODE_ACC, 16'h0001, 2'd0);
    tests++;
    if (bus.done !== 1'b1 || bus.reg_out !== 16'h0004 || bus.acc_cnt !== 2'd0) begin
      fails++;
      $display("FAIL mid_done: done=%b reg_out=%h acc_cnt=%0d expected 1/0004/0", bus.done, bus.reg_out, bus.acc_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reset_enable_low();
    test_enable_gating();
    test_full_product();
    test_overflow();
    test_shift();
    test_reset_mid_product();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_shift_reg.md
Name: acc_shift_reg

Overview:
- Parametrised successor to the fixed 16-bit clearable product register used by the sequential multiplier.
- Holds the running product and supports four modes: hold, load, shifted accumulate and logical right shift.
- Tracks a sticky overflow flag and an accumulation count, and emits a one-cycle done pulse after NUM_ACC accumulations.
- Sits between the partial-product generator and the multiplier output, and is sequenced by the multiplier control FSM.

Parameters:
- WIDTH, 16: register and datain width. Must be a multiple of SHIFT_STEP.
- SHIFT_STEP, 4: bit granularity of the accumulate alignment and of the right shift.
- NUM_ACC, 4: number of ACC operations that completes one product. Must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- sclr  in  1  synchronous active-low clear. Has priority over everything and is independent of clk_en.
- clk_en  in  1  operation enable. When 0, all state holds.
- mode  in  2  00 HOLD, 01 LOAD, 10 ACC, 11 SHIFT.
- datain  in  WIDTH  load value or partial product.
- shift_amt  in  clog2(WIDTH/SHIFT_STEP)  ACC alignment, applied as shift_amt*SHIFT_STEP bits to the left.
- reg_out  out  WIDTH  register contents.
- ovf  out  1  sticky overflow.
- acc_cnt  out  clog2(NUM_ACC)  completed accumulations in the current product.
- done  out  1  one-cycle pulse when a product completes.

Behaviour:
- Reset: at a rising clk with sclr=0, reg_out=0, ovf=0, acc_cnt=0 and done=0, regardless of clk_en and mode.
- Enable gating: with sclr=1 and clk_en=0, reg_out, ovf and acc_cnt hold, and done=0 on the next cycle.
- The following rules apply with sclr=1 and clk_en=1, one operation per edge, with single-cycle latency.
- HOLD: all state holds and done=0.
- LOAD:
  - reg_out<=datain, ovf<=0, acc_cnt<=0.
  - Aborts any partial product; no done pulse.
- ACC:
  - Form aligned = datain << (shift_amt*SHIFT_STEP), computed at 2*WIDTH bits.
  - Form sum = reg_out + aligned[WIDTH-1:0], computed at WIDTH+1 bits.
  - reg_out <= sum[WIDTH-1:0].
  - ovf <= ovf | sum[WIDTH] | (aligned[2*WIDTH-1:WIDTH] != 0).
  - If acc_cnt==NUM_ACC-1: acc_cnt<=0 and done<=1. Otherwise acc_cnt<=acc_cnt+1 and done<=0.
- SHIFT:
  - reg_out <= reg_out >> SHIFT_STEP, logical, zero-filled.
  - ovf and acc_cnt hold; done=0.
- done is registered and is high in the same cycle that reg_out first shows the completed sum. It is never high for two consecutive cycles unless two products complete back to back.
- Wrap-around: the ACC immediately after a completing ACC starts a new count (acc_cnt 0 to 1). reg_out is not auto-cleared; the FSM issues LOAD 0 between products.
- Reset mid-product discards the partial count; the next product needs a full NUM_ACC ACCs.
- No X propagation: every output has a defined value from the first reset edge.

Decomposition:
- Package acc_shift_pkg holds:
  - MODE_HOLD, MODE_LOAD, MODE_ACC and MODE_SHIFT localparams, plus a 2-bit mode typedef.
  - A clog2-based width helper for shift_amt and acc_cnt.
- One natural combinational sub-module, pp_align. It produces aligned[WIDTH-1:0] and an out-of-range flag from datain and shift_amt.
- The register, counter and flags stay in acc_shift_reg.

Test Plan:
- Use WIDTH=16, SHIFT_STEP=4, NUM_ACC=4 for all scenarios.
- Reset with enable low: hold sclr=0 with clk_en=0 for 2 cycles after arbitrary state -> reg_out=0x0000, ovf=0, acc_cnt=0, done=0.
- Enable gating: LOAD 0x1234, then clk_en=0 with mode=LOAD and datain=0xFFFF for 3 cycles -> reg_out stays 0x1234.
- Full product:
  - Stimulus: LOAD 0, then ACC (0x0006,0), (0x000C,1), (0x0009,2), (0x0002,3).
  - Expected: reg_out=0x29C6, done high for exactly one cycle aligned with 0x29C6, acc_cnt=0, ovf=0.
- Overflow via carry: LOAD 0xF000, then ACC (0x1000,0) -> reg_out=0x0000 and ovf=1.
- Overflow via truncation: continue with ACC (0x0010,3) -> ovf remains 1. A following LOAD 0x0001 -> ovf=0.
- Shift: LOAD 0xABCD, then SHIFT, SHIFT -> reg_out=0x0ABC, then 0x00AB. acc_cnt unchanged, done=0.
- Reset mid-product:
  - Stimulus: LOAD 0, ACC twice (acc_cnt=2), then sclr=0 with clk_en=0.
  - Expected after the clear: all outputs 0.
  - Next: 3 ACCs give no done; the 4th ACC gives the done pulse.
